// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock; done pulses BIN_W cycles after start.
// start is ignored while busy; results saturate to all nines with overflow set.
// Optional leading-zero blanking (4'hF) under macro BINARY_BCD_LZB_EN.
module binary_bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               oflag_q, oflag_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   dig_shift;
  logic               ovf_shift;
  logic [BCD_W-1:0]   res;
`ifdef BINARY_BCD_LZB_EN
  logic               seen_nz;
`endif

  // Adjust every digit before the shift so the doubling carries correctly into the next digit.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    dig_shift = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
    ovf_shift = ovf_q | adj[BCD_W-1];
  end

  always_comb begin
    res = dig_shift;
`ifdef BINARY_BCD_LZB_EN
    seen_nz = 1'b0;
`endif
    if (ovf_shift) begin
      res = {DIGITS{4'h9}};
    end else begin
`ifdef BINARY_BCD_LZB_EN
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (res[4*i +: 4] != 4'h0) begin
          seen_nz = 1'b1;
        end else if (!seen_nz) begin
          res[4*i +: 4] = 4'hF;
        end
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    oflag_d = oflag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin_in;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        dig_d   = dig_shift;
        ovf_d   = ovf_shift;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          bcd_d   = res;
          oflag_d = ovf_shift;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      oflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      oflag_q <= oflag_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = oflag_q;

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Bench for binary_bcd_seq: a 13-bit/4-digit and a 10-bit/3-digit instance checked every cycle against a value-level model.
module tb_binary_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [12:0] bin_a;
  logic [9:0]  bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_a;
  logic [11:0] bcd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  binary_bcd_seq #(.BIN_W(13), .DIGITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  binary_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  // Expected result {overflow, bcd} from the decimal value of v.
  function automatic logic [40:0] ref_bcd(input int unsigned v, input int d);
    logic [39:0] r;
    longint unsigned lim;
    int unsigned x;
    bit nz;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    r = '0;
    if (longint'(v) >= lim) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
      return {1'b1, r};
    end
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BINARY_BCD_LZB_EN
    nz = 1'b0;
    for (int i = d - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'h0) nz = 1'b1;
      else if (!nz) r[4*i +: 4] = 4'hF;
    end
`else
    nz = 1'b0;
`endif
    return {1'b0, r};
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a conversion occupies BIN_W cycles, then the result appears with a one-cycle done.
  int              rem_a = 0, rem_b = 0;
  int unsigned     val_a = 0, val_b = 0;
  bit              m_done_a = 0, m_done_b = 0;
  logic [40:0]     m_res_a = '0, m_res_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_a = 0; rem_b = 0; m_done_a = 0; m_done_b = 0; m_res_a = '0; m_res_b = '0;
    end else begin
      m_done_a = 0;
      if (rem_a > 0) begin
        rem_a--;
        if (rem_a == 0) begin m_done_a = 1; m_res_a = ref_bcd(val_a, 4); end
      end else if (start_a) begin
        val_a = bin_a; rem_a = 13;
      end
      m_done_b = 0;
      if (rem_b > 0) begin
        rem_b--;
        if (rem_b == 0) begin m_done_b = 1; m_res_b = ref_bcd(val_b, 3); end
      end else if (start_b) begin
        val_b = bin_b; rem_b = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("a_busy", busy_a, rem_a > 0);
      check("a_done", done_a, m_done_a);
      check("a_bcd",  bcd_a,  m_res_a[15:0]);
      check("a_ovf",  ovf_a,  m_res_a[40]);
      check("b_busy", busy_b, rem_b > 0);
      check("b_done", done_b, m_done_b);
      check("b_bcd",  bcd_b,  m_res_b[11:0]);
      check("b_ovf",  ovf_b,  m_res_b[40]);
    end
  end

  // One conversion with a hand-computed literal expectation and latency check.
  task automatic conv(input bit sel, input int unsigned v, input logic [15:0] lit, input logic lit_ovf);
    int waits;
    @(negedge clk);
    if (sel) begin bin_b = 10'(v); start_b = 1'b1; end
    else     begin bin_a = 13'(v); start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    waits = 1;
    while (!(sel ? done_b : done_a) && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check(sel ? "b_latency" : "a_latency", waits, sel ? 11 : 14);
    if (sel) begin
      check("b_literal_bcd", bcd_b, lit[11:0]);
      check("b_literal_ovf", ovf_b, lit_ovf);
    end else begin
      check("a_literal_bcd", bcd_a, lit);
      check("a_literal_ovf", ovf_a, lit_ovf);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    #12;
    check("rst_a_busy", busy_a, 0); check("rst_a_done", done_a, 0);
    check("rst_a_bcd",  bcd_a,  0); check("rst_a_ovf",  ovf_a,  0);
    check("rst_b_busy", busy_b, 0); check("rst_b_bcd",  bcd_b,  0);
    rst_n = 1'b1;

`ifdef BINARY_BCD_LZB_EN
    conv(0, 0,    16'hFFF0, 0);
    conv(0, 42,   16'hFF42, 0);
`else
    conv(0, 0,    16'h0000, 0);
    conv(0, 42,   16'h0042, 0);
`endif
    conv(0, 8191, 16'h8191, 0);
    conv(0, 1234, 16'h1234, 0);
    conv(0, 1005, 16'h1005, 0);
    conv(1, 1000, 16'h0999, 1);
    conv(1, 999,  16'h0999, 0);

    // start held high with bin_in changing every cycle
    @(negedge clk);
    start_a = 1'b1; bin_a = 13'($urandom_range(0, 8191));
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done_a) n++;
      bin_a = 13'($urandom_range(0, 8191));
    end
    start_a = 1'b0;
    check("b2b_done_count", n, 4);
    repeat (20) @(negedge clk);

    // asynchronous reset in the middle of a conversion
    conv(0, 4321, 16'h4321, 0);
    @(negedge clk);
    bin_a = 13'd777; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 0); check("arst_done", done_a, 0);
    check("arst_bcd",  bcd_a,  0); check("arst_ovf",  ovf_a,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) n++;
    end
    check("arst_no_done", n, 0);
    conv(0, 4321, 16'h4321, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
